// File: rtl/fifo_rd_stream.sv
// Read-side adapter: paces synchronous-read FIFO pulses into a 2-entry buffer streamed out on valid/ready.
// Optional starvation counter enabled by defining FIFO_RD_STARVE_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  starve_cnt
);

  logic [1:0]            occ;
  logic                  inflight;
  logic                  discard;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  pop;
  logic                  capture;
  logic [2:0]            pending;

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[head];
  assign pop       = out_valid && out_ready;
  // A word arriving during a flush is dropped along with the buffer contents.
  assign capture   = inflight && !discard && !flush;
  assign pending   = {1'b0, occ} + {2'b00, inflight};
  // The pop credit lets a read issue into the slot being vacated this cycle.
  assign fifo_rd   = !reset && !flush && !fifo_empty && (pending < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      discard  <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= fifo_rd;
      discard  <= flush && inflight;
      if (flush) begin
        occ  <= 2'd0;
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (capture) begin
          mem[tail] <= fifo_rdata;
          tail      <= ~tail;
        end
        if (pop)
          head <= ~head;
        case ({capture, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(capture && occ == 2'd2 && !pop));

`ifdef FIFO_RD_STARVE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (out_ready && !out_valid && !flush && starve_cnt != '1)
      starve_cnt <= starve_cnt + CNT_WIDTH'(1);
  end
`else
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model plus an in-order scoreboard of expected words.
// Starvation expectation follows FIFO_RD_STARVE_CNT_EN.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [23:0] fifo_rdata = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready = 1'b0;
  logic [15:0] starve_cnt;

  fifo_rd_stream #(.DATA_WIDTH(24), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_rdata(fifo_rdata), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int overreads = 0;
  int rd_cnt, pop_cnt, max_out;
  logic [23:0] q[$];
  logic [23:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [23:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
  endtask

  // Synchronous-read FIFO: data appears the cycle after rd, empty is registered.
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (q.size() == 0) overreads++;
      else fifo_rdata <= q.pop_front();
    end
    fifo_empty <= (q.size() == 0);
  end

  // Scoreboard and stream-protocol monitor.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_data", {8'b0, out_data}, {8'b0, prev_data});
      end
      if (rd_cnt - pop_cnt > max_out) max_out = rd_cnt - pop_cnt;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", {8'b0, out_data}, 32'hFFFF_FFFF);
        else chk("pop_data", {8'b0, out_data}, {8'b0, exp_q.pop_front()});
        pop_cnt++;
      end
      if (fifo_rd) rd_cnt++;
      prev_hold = out_valid && !out_ready && !flush;
      prev_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    flush = 1'b0;
    out_ready = rdy;
    q.delete();
    exp_q.delete();
    rd_cnt = 0;
    pop_cnt = 0;
    max_out = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [23:0] w);
    q.push_back(w);
    exp_q.push_back(w);
  endtask

  int pushed;
  int exp_starve;

  initial begin
    rd_cnt = 0; pop_cnt = 0; max_out = 0;
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {8'b0, out_data}, 32'd0);
    chk("rst_rd", {31'b0, fifo_rd}, 32'd0);
    chk("rst_starve", {16'b0, starve_cnt}, 32'd0);

    // Four preloaded words at full throughput.
    do_reset(1'b1);
    for (int i = 1; i <= 4; i++) push(24'(i));
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("tput_rd%0d", k), {31'b0, fifo_rd}, {31'b0, k < 4});
      chk($sformatf("tput_valid%0d", k), {31'b0, out_valid}, {31'b0, k >= 2 && k < 6});
      step();
    end
    chk("tput_delivered", pop_cnt, 32'd4);

    // Backpressure: only two reads outstanding, head stable, then drain.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) push(24'h100 + 24'(i));
    repeat (8) step();
    chk("bp_rd_count", rd_cnt, 32'd2);
    chk("bp_data", {8'b0, out_data}, 32'h100);
    out_ready = 1'b1;
    repeat (10) step();
    chk("bp_delivered", pop_cnt, 32'd5);
    chk("bp_max_out", {31'b0, max_out <= 2}, 32'd1);

    // Alternating ready over eight words.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) push(24'h200 + 24'(i));
    for (int c = 0; c < 30; c++) begin
      out_ready = c[0];
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    chk("alt_delivered", pop_cnt, 32'd8);
    chk("alt_left", exp_q.size(), 32'd0);
    chk("alt_max_out", {31'b0, max_out <= 2}, 32'd1);

    // Random trickle fill with random ready.
    do_reset(1'b0);
    pushed = 0;
    for (int c = 0; c < 400 && pushed < 40; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        push(24'($urandom));
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    repeat (20) step();
    chk("rand_pushed", pushed, 32'd40);
    chk("rand_delivered", pop_cnt, 32'd40);
    chk("rand_max_out", {31'b0, max_out <= 2}, 32'd1);

    // Flush with one buffered and one in-flight word: words 1,2 dropped.
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) q.push_back(24'(i));
    for (int i = 3; i <= 5; i++) exp_q.push_back(24'(i));
    step();
    step();
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_no_rd", {31'b0, fifo_rd}, 32'd0);
    chk("flush_valid_kept", {31'b0, out_valid}, 32'd1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_next", {31'b0, out_valid}, 32'd0);
    step();
    step();
    @(negedge clk);
    chk("flush_resume_valid", {31'b0, out_valid}, 32'd1);
    chk("flush_resume_data", {8'b0, out_data}, 32'd3);
    step();
    out_ready = 1'b1;
    repeat (10) step();
    chk("flush_left", exp_q.size(), 32'd0);
    chk("flush_overreads", overreads, 32'd0);

    // Asynchronous reset mid-stream.
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) push(24'h300 + 24'(i));
    step();
    step();
    step();
    #1;
    chk("ar_valid_before", {31'b0, out_valid}, 32'd1);
    chk("ar_rd_before", {31'b0, fifo_rd}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    q.delete();
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_data", {8'b0, out_data}, 32'd0);
    chk("ar_rd", {31'b0, fifo_rd}, 32'd0);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) push(24'hA00 + 24'(i));
    repeat (10) step();
    chk("ar_restart_delivered", pop_cnt, 32'd3);
    chk("ar_restart_left", exp_q.size(), 32'd0);

    // Starvation counter with an empty FIFO and ready held high.
    do_reset(1'b1);
    repeat (10) step();
`ifdef FIFO_RD_STARVE_CNT_EN
    exp_starve = 10;
`else
    exp_starve = 0;
`endif
    chk("starve_cnt", {16'b0, starve_cnt}, 32'(exp_starve));
    chk("overreads", overreads, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
